// File: rtl/sram_bist_sequencer.sv
// RTAP-side master for the nibble-serial SRAM BIST debug bus: serializes one
// read/write request into the wrapper command stream and collects read nibbles.
`ifndef BIST_OP_WIDTH
`define BIST_OP_WIDTH 3
`endif
`ifndef SRAM_WRAPPER_BUS_WIDTH
`define SRAM_WRAPPER_BUS_WIDTH 8
`endif

module sram_bist_sequencer #(
    parameter int RSP_DELAY = 0
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               req_valid,
    output logic                               req_ready,
    input  logic                               req_write,
    input  logic [7:0]                         req_sram_id,
    input  logic [7:0]                         req_bsel,
    input  logic [15:0]                        req_addr,
    input  logic [191:0]                       req_wdata,
    output logic                               rsp_valid,
    input  logic                               rsp_ready,
    output logic                               rsp_write,
    output logic [255:0]                       rsp_rdata,
    output logic [`BIST_OP_WIDTH-1:0]          rtap_srams_bist_command,
    output logic [`SRAM_WRAPPER_BUS_WIDTH-1:0] rtap_srams_bist_data,
    input  logic [`SRAM_WRAPPER_BUS_WIDTH-1:0] srams_rtap_data
);
    localparam int OPW = `BIST_OP_WIDTH;
    localparam int DW  = `SRAM_WRAPPER_BUS_WIDTH;

    localparam logic [OPW-1:0] OP_NOP        = OPW'(0);
    localparam logic [OPW-1:0] OP_SHIFT_ID   = OPW'(1);
    localparam logic [OPW-1:0] OP_SHIFT_BSEL = OPW'(2);
    localparam logic [OPW-1:0] OP_SHIFT_ADDR = OPW'(3);
    localparam logic [OPW-1:0] OP_READ       = OPW'(4);
    localparam logic [OPW-1:0] OP_SHIFT_DATA = OPW'(5);

    typedef enum logic [3:0] {
        S_IDLE, S_ID, S_BSEL, S_ADDR, S_OP, S_RGAP,
        S_RSHIFT, S_RDRAIN, S_WDATA, S_WGAP, S_RESP
    } state_t;

    state_t         state, state_n;
    logic [6:0]     cnt, cnt_n;
    logic           wr_q;
    logic [7:0]     id_q, bsel_q, id_src;
    logic [15:0]    addr_q;
    logic [191:0]   wdata_q;
    logic [255:0]   rdata_q;
    logic [OPW-1:0] cmd_q, cmd_n;
    logic [DW-1:0]  data_q;
    logic [3:0]     nib_n;
    logic [5:0]     wsel;
    logic           accept;
    logic [2:0]     shf_q;
    logic [3:0]     shf_all;
    logic           cap_en;
    logic           unused_ok;

    assign accept    = req_valid && (state == S_IDLE);
    assign req_ready = (state == S_IDLE);
    assign rsp_valid = (state == S_RESP);
    assign rsp_write = wr_q;
    assign rsp_rdata = rdata_q;
    assign rtap_srams_bist_command = cmd_q;
    assign rtap_srams_bist_data    = data_q;
    assign unused_ok = ^srams_rtap_data[DW-1:4];

    // First ID nibble goes out the cycle after acceptance, before id_q is loaded.
    assign id_src = accept ? req_sram_id : id_q;

    // Marks RSHIFT cycles; delayed copies line capture up with the return pipe.
    assign shf_all = {shf_q, (state == S_RSHIFT)};
    assign cap_en  = shf_all[RSP_DELAY];

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        unique case (state)
            S_IDLE:   if (req_valid) begin state_n = S_ID; cnt_n = 7'd0; end
            S_ID:     if (cnt == 7'd1) begin state_n = S_BSEL; cnt_n = 7'd0; end
                      else cnt_n = cnt + 7'd1;
            S_BSEL:   if (cnt == 7'd1) begin state_n = S_ADDR; cnt_n = 7'd0; end
                      else cnt_n = cnt + 7'd1;
            S_ADDR:   if (cnt == 7'd3) begin
                          state_n = wr_q ? S_WDATA : S_OP;
                          cnt_n   = 7'd0;
                      end else cnt_n = cnt + 7'd1;
            S_OP:     state_n = S_RGAP;
            S_RGAP:   begin state_n = S_RSHIFT; cnt_n = 7'd0; end
            S_RSHIFT: if (cnt == 7'd63) begin
                          state_n = (RSP_DELAY == 0) ? S_RESP : S_RDRAIN;
                          cnt_n   = 7'd1;
                      end else cnt_n = cnt + 7'd1;
            S_RDRAIN: if (cnt == 7'(RSP_DELAY)) begin state_n = S_RESP; cnt_n = 7'd0; end
                      else cnt_n = cnt + 7'd1;
            S_WDATA:  if (cnt == 7'd47) begin state_n = S_WGAP; cnt_n = 7'd0; end
                      else cnt_n = cnt + 7'd1;
            S_WGAP:   if (cnt == 7'd1) begin state_n = S_RESP; cnt_n = 7'd0; end
                      else cnt_n = cnt + 7'd1;
            S_RESP:   if (rsp_ready) begin state_n = S_IDLE; cnt_n = 7'd0; end
            default:  begin state_n = S_IDLE; cnt_n = 7'd0; end
        endcase
    end

    // Bus values are derived from the next state so the registered outputs
    // line up with the state the sequencer is entering.
    always_comb begin
        cmd_n = OP_NOP;
        nib_n = 4'h0;
        wsel  = 6'd47 - cnt_n[5:0];
        case (state_n)
            S_ID:     begin cmd_n = OP_SHIFT_ID;   nib_n = cnt_n[0] ? id_src[3:0] : id_src[7:4]; end
            S_BSEL:   begin cmd_n = OP_SHIFT_BSEL; nib_n = cnt_n[0] ? bsel_q[3:0] : bsel_q[7:4]; end
            S_ADDR:   begin cmd_n = OP_SHIFT_ADDR; nib_n = addr_q[{~cnt_n[1:0], 2'b00} +: 4]; end
            S_OP:     cmd_n = OP_READ;
            S_RSHIFT: cmd_n = OP_SHIFT_DATA;
            S_WDATA:  begin cmd_n = OP_SHIFT_DATA; nib_n = wdata_q[{wsel, 2'b00} +: 4]; end
            default:  ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= S_IDLE;
            cnt     <= 7'd0;
            cmd_q   <= OP_NOP;
            data_q  <= '0;
            wr_q    <= 1'b0;
            id_q    <= 8'h0;
            bsel_q  <= 8'h0;
            addr_q  <= 16'h0;
            wdata_q <= '0;
            rdata_q <= '0;
            shf_q   <= 3'b0;
        end else begin
            state  <= state_n;
            cnt    <= cnt_n;
            cmd_q  <= cmd_n;
            data_q <= DW'(nib_n);
            shf_q  <= shf_all[2:0];
            if (accept) begin
                wr_q    <= req_write;
                id_q    <= req_sram_id;
                bsel_q  <= req_bsel;
                addr_q  <= req_addr;
                wdata_q <= req_wdata;
                rdata_q <= '0;
            end else if (cap_en) begin
                rdata_q <= {rdata_q[251:0], srams_rtap_data[3:0]};
            end
        end
    end
endmodule

// File: tb/tb_sram_bist_sequencer.sv
// Bench: two sequencers (RSP_DELAY 0 and 2), each driving a behavioural sp_ram
// wrapper at ID 0x12; bus traces and responses checked against a request-level model.
`ifndef BIST_OP_WIDTH
`define BIST_OP_WIDTH 3
`endif
`ifndef SRAM_WRAPPER_BUS_WIDTH
`define SRAM_WRAPPER_BUS_WIDTH 8
`endif

module tb_sram_bist_sequencer;
    localparam int OPW = `BIST_OP_WIDTH;
    localparam int DW  = `SRAM_WRAPPER_BUS_WIDTH;
    localparam logic [OPW-1:0] C_NOP  = OPW'(0);
    localparam logic [OPW-1:0] C_ID   = OPW'(1);
    localparam logic [OPW-1:0] C_BSEL = OPW'(2);
    localparam logic [OPW-1:0] C_ADDR = OPW'(3);
    localparam logic [OPW-1:0] C_READ = OPW'(4);
    localparam logic [OPW-1:0] C_DATA = OPW'(5);
    localparam logic [7:0]     WID    = 8'h12;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic           rq_valid [2], rq_ready [2], rq_write [2];
    logic [7:0]     rq_id    [2], rq_bsel  [2];
    logic [15:0]    rq_addr  [2];
    logic [191:0]   rq_wdata [2];
    logic           rs_valid [2], rs_ready [2], rs_write [2];
    logic [255:0]   rs_rdata [2];
    logic [OPW-1:0] cmd      [2];
    logic [DW-1:0]  bdat     [2], ret [2];

    logic [15:0] ref_mem [2][256];
    int n_tests = 0;
    int n_fail  = 0;

    for (genvar g = 0; g < 2; g++) begin : g_dut
        localparam int DLY = 2 * g;

        sram_bist_sequencer #(.RSP_DELAY(DLY)) u_dut (
            .clk(clk), .rst(rst),
            .req_valid(rq_valid[g]), .req_ready(rq_ready[g]), .req_write(rq_write[g]),
            .req_sram_id(rq_id[g]), .req_bsel(rq_bsel[g]), .req_addr(rq_addr[g]),
            .req_wdata(rq_wdata[g]),
            .rsp_valid(rs_valid[g]), .rsp_ready(rs_ready[g]), .rsp_write(rs_write[g]),
            .rsp_rdata(rs_rdata[g]),
            .rtap_srams_bist_command(cmd[g]), .rtap_srams_bist_data(bdat[g]),
            .srams_rtap_data(ret[g])
        );

        // Behavioural wrapper: 16-bit words, commits a write only after a full
        // 48-nibble data shift followed by NOP.
        logic [7:0]   w_id = 8'h0;
        logic [7:0]   w_addr = 8'h0;
        logic [15:0]  w_wd = 16'h0;
        logic [255:0] w_rd = '0;
        logic         w_rdmode = 1'b0, w_load = 1'b0;
        int           w_nd = 0;
        logic [15:0]  mem [256];
        logic [3:0]   w_ret, p1 = 4'h0, p2 = 4'h0;

        initial for (int i = 0; i < 256; i++) mem[i] = 16'h0;

        always @(posedge clk) begin
            case (cmd[g])
                C_ID:   begin w_id <= {w_id[3:0], bdat[g][3:0]}; w_nd <= 0; w_rdmode <= 1'b0; w_load <= 1'b0; end
                C_ADDR: w_addr <= {w_addr[3:0], bdat[g][3:0]};
                C_READ: begin w_rdmode <= 1'b1; w_load <= 1'b1; end
                C_DATA: if (w_rdmode) w_rd <= w_rd << 4;
                        else begin w_wd <= {w_wd[11:0], bdat[g][3:0]}; w_nd <= w_nd + 1; end
                C_NOP: begin
                    if (w_load && w_id == WID) w_rd <= {240'h0, mem[w_addr]};
                    if (!w_rdmode && w_nd == 48 && w_id == WID) mem[w_addr] <= w_wd;
                    w_load <= 1'b0;
                    w_nd   <= 0;
                end
                default: ;
            endcase
            p1 <= w_ret;
            p2 <= p1;
        end
        assign w_ret  = (cmd[g] == C_DATA && w_rdmode && w_id == WID) ? w_rd[255:252] : 4'h0;
        assign ret[g] = DW'((DLY == 0) ? w_ret : p2);
    end

    task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic scramble(input int d);
        rq_write[d] = 1'($urandom);
        rq_id[d]    = 8'($urandom);
        rq_bsel[d]  = 8'($urandom);
        rq_addr[d]  = 16'($urandom);
        rq_wdata[d] = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    endtask

    // One transaction on DUT d; called at #1 after a rising edge with DUT idle.
    task automatic txn(input int d, input logic wr, input logic [7:0] id, input logic [15:0] addr,
                       input logic [191:0] wd, input int hold, input int abort_at,
                       output logic [255:0] got, output int lat);
        logic [OPW-1:0] qc[$];
        logic [3:0]     qn[$];
        logic [7:0]     bs;
        logic [255:0]   exp_rd;
        bs  = 8'($urandom);
        got = '0;
        lat = 0;
        for (int k = 1; k >= 0; k--) begin qc.push_back(C_ID);   qn.push_back(id[4*k +: 4]); end
        for (int k = 1; k >= 0; k--) begin qc.push_back(C_BSEL); qn.push_back(bs[4*k +: 4]); end
        for (int k = 3; k >= 0; k--) begin qc.push_back(C_ADDR); qn.push_back(addr[4*k +: 4]); end
        if (wr) begin
            for (int k = 47; k >= 0; k--) begin qc.push_back(C_DATA); qn.push_back(wd[4*k +: 4]); end
            repeat (2) begin qc.push_back(C_NOP); qn.push_back(4'h0); end
        end else begin
            qc.push_back(C_READ); qn.push_back(4'h0);
            qc.push_back(C_NOP);  qn.push_back(4'h0);
            repeat (64) begin qc.push_back(C_DATA); qn.push_back(4'h0); end
            repeat (2 * d) begin qc.push_back(C_NOP); qn.push_back(4'h0); end
        end
        exp_rd = '0;
        if (!wr && id == WID) exp_rd = {240'h0, ref_mem[d][addr[7:0]]};

        chk("idle req_ready", 256'(rq_ready[d]), 256'(1));
        rq_valid[d] = 1'b1; rq_write[d] = wr; rq_id[d] = id;
        rq_bsel[d] = bs; rq_addr[d] = addr; rq_wdata[d] = wd;
        @(posedge clk); #1;
        for (int c = 0; c < qc.size(); c++) begin
            chk("bus cmd", 256'(cmd[d]), 256'(qc[c]));
            chk("bus nibble", 256'(bdat[d]), 256'(qn[c]));
            chk("busy req_ready", 256'(rq_ready[d]), 256'(0));
            chk("early rsp_valid", 256'(rs_valid[d]), 256'(0));
            if (c == abort_at) begin
                rq_valid[d] = 1'b0;
                rst = 1'b1;
                #1;
                chk("abort cmd", 256'(cmd[d]), 256'(C_NOP));
                chk("abort req_ready", 256'(rq_ready[d]), 256'(1));
                chk("abort rsp_valid", 256'(rs_valid[d]), 256'(0));
                @(posedge clk); #1;
                rst = 1'b0;
                @(posedge clk); #1;
                return;
            end
            scramble(d);
            rq_valid[d] = ($urandom_range(0, 3) == 0);
            @(posedge clk); #1;
        end
        rq_valid[d] = 1'b0;
        lat = qc.size() + 1;
        while (!rs_valid[d] && lat < qc.size() + 100) begin
            @(posedge clk); #1;
            lat++;
        end
        got = rs_rdata[d];
        chk("rsp_valid", 256'(rs_valid[d]), 256'(1));
        chk("rsp latency", 256'(lat), 256'(qc.size() + 1));
        chk("rsp_write", 256'(rs_write[d]), 256'(wr));
        chk("rsp_rdata", got, exp_rd);
        chk("resp cmd", 256'(cmd[d]), 256'(C_NOP));
        for (int h = 0; h < hold; h++) begin
            scramble(d);
            rq_valid[d] = 1'($urandom);
            @(posedge clk); #1;
            chk("held rsp_valid", 256'(rs_valid[d]), 256'(1));
            chk("held rsp_rdata", rs_rdata[d], exp_rd);
            chk("held req_ready", 256'(rq_ready[d]), 256'(0));
            chk("held cmd", 256'(cmd[d]), 256'(C_NOP));
        end
        rq_valid[d] = 1'b0;
        rs_ready[d] = 1'b1;
        @(posedge clk); #1;
        rs_ready[d] = 1'b0;
        chk("post req_ready", 256'(rq_ready[d]), 256'(1));
        chk("post rsp_valid", 256'(rs_valid[d]), 256'(0));
        chk("post cmd", 256'(cmd[d]), 256'(C_NOP));
        if (wr && id == WID) ref_mem[d][addr[7:0]] = wd[15:0];
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [255:0] got;
        int lat;
        logic [191:0] wd;
        logic [7:0] id;
        rst = 1'b1;
        for (int d = 0; d < 2; d++) begin
            rq_valid[d] = 1'b0; rs_ready[d] = 1'b0;
            rq_write[d] = 1'b0; rq_id[d] = 8'h0; rq_bsel[d] = 8'h0;
            rq_addr[d] = 16'h0; rq_wdata[d] = '0;
            for (int i = 0; i < 256; i++) ref_mem[d][i] = 16'h0;
        end
        repeat (2) @(posedge clk);
        #1;
        for (int d = 0; d < 2; d++) begin
            chk("reset req_ready", 256'(rq_ready[d]), 256'(1));
            chk("reset rsp_valid", 256'(rs_valid[d]), 256'(0));
            chk("reset cmd", 256'(cmd[d]), 256'(C_NOP));
            chk("reset data", 256'(bdat[d]), 256'(0));
            chk("reset rdata", rs_rdata[d], 256'(0));
        end
        rst = 1'b0;
        @(posedge clk); #1;

        for (int d = 0; d < 2; d++) begin
            wd = {$urandom, $urandom, $urandom, $urandom, $urandom, 16'($urandom), 16'hABCD};
            txn(d, 1'b1, WID, 16'h0005, wd, 0, -1, got, lat);
            chk("write latency literal", 256'(lat), 256'(59));
            txn(d, 1'b0, WID, 16'h0005, '0, 0, -1, got, lat);
            chk("read ABCD literal", 256'(got[15:0]), 256'(16'hABCD));
            chk("read top literal", 256'(got[255:240]), 256'(0));
            chk("read latency literal", 256'(lat), 256'(75 + 2 * d));

            wd = {176'h0, 16'hBEEF};
            wd[191:160] = $urandom;
            txn(d, 1'b1, WID, 16'h0003, wd, 0, -1, got, lat);
            txn(d, 1'b0, WID, 16'h0003, '0, 0, -1, got, lat);
            chk("readback BEEF literal", 256'(got[15:0]), 256'(16'hBEEF));

            txn(d, 1'b0, 8'h34, 16'h0005, '0, 0, -1, got, lat);
            chk("absent id literal", got, 256'(0));
            txn(d, 1'b0, WID, 16'h0005, '0, 0, -1, got, lat);
            chk("after absent literal", 256'(got[15:0]), 256'(16'hABCD));

            txn(d, 1'b0, WID, 16'h0003, '0, 10, -1, got, lat);
            chk("held read literal", 256'(got[15:0]), 256'(16'hBEEF));

            txn(d, 1'b1, WID, 16'h0003, {176'h0, 16'h1111}, 0, 28, got, lat);
            txn(d, 1'b0, WID, 16'h0003, '0, 0, -1, got, lat);
            chk("aborted write literal", 256'(got[15:0]), 256'(16'hBEEF));

            for (int t = 0; t < 14; t++) begin
                id = ($urandom_range(0, 3) == 0) ? 8'($urandom) : WID;
                wd = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
                txn(d, 1'($urandom), id, {8'($urandom), 5'h0, 3'($urandom)}, wd,
                    $urandom_range(0, 3), -1, got, lat);
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
